// File: rtl/keypad_encoder.sv
// keypad_encoder: 16-line keypad front end.
// Raw key lines are synchronized, priority-encoded (highest line wins),
// debounced on both press and release, and reported as a one-cycle
// `pressed` strobe with the key code on `buttonBus`.
//
// Optional feature: define KEYPAD_REPEAT_EN to enable auto-repeat for the
// UP (4'hC) and DOWN (4'hD) keys while they are held. Without the macro the
// HELD state never strobes and REPEAT_CYCLES is not used by the datapath.
//
// Handshake: there is no ready/backpressure. `pressed` is a one-cycle valid
// strobe; `buttonBus` carries the code only in that cycle and is 4'h0 at all
// other times. A consumer must sample both on the same rising edge.
module keypad_encoder #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd1000,
  parameter logic [15:0] REPEAT_CYCLES   = 16'd50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] keys,
  output logic [3:0]  buttonBus,
  output logic        pressed,
  output logic        keyHeld
);

  // Zero is the only out-of-range value for a 16-bit count; catch it at
  // elaboration so a bad configuration never silently wraps the counter.
  if (DEBOUNCE_CYCLES == 16'd0) begin : g_bad_debounce
    $error("keypad_encoder: DEBOUNCE_CYCLES must be in 1..65535");
  end
  if (REPEAT_CYCLES == 16'd0) begin : g_bad_repeat
    $error("keypad_encoder: REPEAT_CYCLES must be in 1..65535");
  end

  localparam logic [15:0] DEBOUNCE_LAST = DEBOUNCE_CYCLES - 16'd1;
`ifdef KEYPAD_REPEAT_EN
  localparam logic [15:0] REPEAT_LAST   = REPEAT_CYCLES - 16'd1;
`endif

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_HELD     = 2'd2,
    S_RELEASE  = 2'd3
  } state_t;

  // ------------------------------------------------------------------
  // Synchronizer
  // ------------------------------------------------------------------
  logic [15:0] sync1_q;
  logic [15:0] sync2_q;
  logic [15:0] syncKeys;

  // Two flops per line bring the asynchronous key inputs into clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 16'h0000;
      sync2_q <= 16'h0000;
    end else begin
      sync1_q <= keys;
      sync2_q <= sync1_q;
    end
  end

  assign syncKeys = sync2_q;

  // ------------------------------------------------------------------
  // Priority encoder
  // ------------------------------------------------------------------
  logic [3:0] enc_code;
  logic       any_valid;

  // Scan upward so the highest set line is the last one written and wins.
  always_comb begin
    enc_code = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (syncKeys[i]) begin
        enc_code = 4'(i);
      end
    end
  end

  assign any_valid = |syncKeys;

  // ------------------------------------------------------------------
  // Debounce FSM
  // ------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  cand_q, cand_d;
  logic [3:0]  bus_q, bus_d;
  logic        pressed_q, pressed_d;
  logic        held_q, held_d;

  // State, counter, candidate code and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 16'h0000;
      cand_q    <= 4'h0;
      bus_q     <= 4'h0;
      pressed_q <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cand_q    <= cand_d;
      bus_q     <= bus_d;
      pressed_q <= pressed_d;
      held_q    <= held_d;
    end
  end

  // Next-state and next-output logic; the strobe defaults low every cycle
  // so `pressed` can only ever be a single-cycle pulse.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cand_d    = cand_q;
    bus_d     = 4'h0;
    pressed_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = 16'h0000;
        if (any_valid) begin
          state_d = S_DEBOUNCE;
          cand_d  = enc_code;
        end
      end

      S_DEBOUNCE: begin
        if (!any_valid || (enc_code != cand_q)) begin
          // Bounce or a different key: start over from IDLE.
          state_d = S_IDLE;
          cnt_d   = 16'h0000;
        end else if (cnt_q == DEBOUNCE_LAST) begin
          state_d   = S_HELD;
          cnt_d     = 16'h0000;
          pressed_d = 1'b1;
          bus_d     = cand_q;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_HELD: begin
        if (!any_valid) begin
          state_d = S_RELEASE;
          cnt_d   = 16'h0000;
        end else begin
`ifdef KEYPAD_REPEAT_EN
          // Only UP/DOWN repeat, and only while the same key stays on top.
          if ((enc_code == cand_q) && ((cand_q == 4'hC) || (cand_q == 4'hD))) begin
            if (cnt_q == REPEAT_LAST) begin
              // Hold off one cycle if the previous cycle already strobed,
              // which only matters for REPEAT_CYCLES == 1.
              if (!pressed_q) begin
                pressed_d = 1'b1;
                bus_d     = cand_q;
                cnt_d     = 16'h0000;
              end
            end else begin
              cnt_d = cnt_q + 16'd1;
            end
          end else begin
            cnt_d = 16'h0000;
          end
`else
          // Code changes while held are ignored; nothing strobes here.
          cnt_d = 16'h0000;
`endif
        end
      end

      S_RELEASE: begin
        if (any_valid) begin
          // Key came back before the release settled: same press, no strobe.
          state_d = S_HELD;
          cnt_d   = 16'h0000;
        end else if (cnt_q == DEBOUNCE_LAST) begin
          state_d = S_IDLE;
          cnt_d   = 16'h0000;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = 16'h0000;
      end
    endcase

    held_d = (state_d == S_HELD) || (state_d == S_RELEASE);
  end

  assign buttonBus = bus_q;
  assign pressed   = pressed_q;
  assign keyHeld   = held_q;

endmodule

// File: doc/keypad_encoder.md
KEYPAD_ENCODER -- requirements
Module: keypad_encoder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16'd1000: consecutive stable synchronized cycles required to accept a press or release; legal range 1..65535.
REQ-002 SHALL have parameter REPEAT_CYCLES, default 16'd50000: held cycles between auto-repeat strobes (used only under KEYPAD_REPEAT_EN); legal range 1..65535.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  reset: synchronous, active-high.
REQ-005 keys  input  16  raw asynchronous keypad lines, active-high; bit n is key code n (0-9 digits, A STOP, B RESUME, C UP, D DOWN, E ESCAPE, F ENTER).
REQ-006 buttonBus  output  4  registered key code; valid only while pressed=1, otherwise 4'h0.
REQ-007 pressed  output  1  registered one-cycle strobe per accepted key event.
REQ-008 keyHeld  output  1  registered; high while state is HELD or RELEASE.

Function
REQ-009 keys SHALL pass through a 2-flop synchronizer per bit; all further logic uses only synchronized keys (syncKeys).
REQ-010 Priority encode: highest set bit of syncKeys wins (keys[3] and keys[11] both high -> code 4'hB); anyValid = |syncKeys.
REQ-011 FSM states SHALL be IDLE, DEBOUNCE, HELD and RELEASE; 16-bit counter cnt.
REQ-012 IDLE: anyValid -> DEBOUNCE, capture encoded code into cand, cnt<=0; else stay.
REQ-013 DEBOUNCE: if !anyValid or encoded code != cand -> IDLE, cnt<=0; else if cnt==DEBOUNCE_CYCLES-1 -> HELD, cnt<=0, pressed<=1, buttonBus<=cand; else cnt<=cnt+1.
REQ-014 HELD: anyValid -> stay, ignoring code changes; !anyValid -> RELEASE, cnt<=0.
REQ-015 RELEASE: anyValid -> HELD, cnt<=0, no strobe; else if cnt==DEBOUNCE_CYCLES-1 -> IDLE; else cnt<=cnt+1.
REQ-016 Latency: raw key stable high from edge 1 SHALL yield pressed=1 for exactly the one cycle following edge DEBOUNCE_CYCLES+3.
REQ-017 pressed SHALL never be high two consecutive cycles; buttonBus SHALL return to 4'h0 the cycle after the strobe.
REQ-018 Without auto-repeat, exactly one strobe per press, regardless of hold length or bounce during release.
REQ-019 cnt SHALL never wrap; it is cleared on every state transition.

Reset
REQ-020 rst=1 at a rising edge SHALL clear synchronizer flops, cnt and cand, force IDLE, and drive buttonBus=4'h0, pressed=0, keyHeld=0 from the next cycle.
REQ-021 rst during DEBOUNCE SHALL suppress the pending strobe; a key still held after rst releases SHALL be treated as a new press with full debounce latency.
REQ-022 rst has priority over all simultaneous key activity.

Configuration
REQ-023 Macro KEYPAD_REPEAT_EN defined: in HELD with anyValid and encoded code == cand and cand in {4'hC, 4'hD}, cnt increments; at cnt==REPEAT_CYCLES-1 emit one strobe with cand and clear cnt; a code change or leaving HELD clears cnt.
REQ-024 Macro KEYPAD_REPEAT_EN undefined: no repeat logic or REPEAT_CYCLES counter use; HELD never strobes.

Verification (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10)
REQ-025 After reset, keys=16'h0020 held steady -> pressed=1, buttonBus=4'h5 exactly one cycle after edge 7; no further strobe while held; keyHeld=1.
REQ-026 keys=16'h0808 stable -> single strobe with buttonBus=4'hB.
REQ-027 keys[2] toggled high 2 cycles/low 1 cycle repeatedly, then stable -> no strobe until 4 consecutive stable synchronized cycles; then one strobe, code 4'h2.
REQ-028 After strobe, keys low 2 cycles then high again -> no second strobe; keys low >=4 synchronized cycles then pressed again -> second strobe.
REQ-029 rst pulsed while in DEBOUNCE with keys[15] high -> no strobe before reset; first strobe (4'hF) 7 edges after rst deasserts.
REQ-030 KEYPAD_REPEAT_EN defined, keys[12] held -> initial strobe 4'hC then a strobe every 10 cycles; keys[5] held -> exactly one strobe.
